// File: rtl/fa_pkg.sv
// Shared widths, state encoding and float field positions for the
// G.726 signal-estimate accumulator.
package fa_pkg;

  localparam int unsigned COEF_W = 16;
  localparam int unsigned FLT_W  = 11;
  localparam int unsigned ACC_W  = 16;
  localparam int unsigned EST_W  = 15;

  // Float operand layout {sign, exp[3:0], mant[5:0]}
  localparam int unsigned FLT_SIGN    = 10;
  localparam int unsigned FLT_EXP_HI  = 9;
  localparam int unsigned FLT_EXP_LO  = 6;
  localparam int unsigned FLT_MANT_HI = 5;
  localparam int unsigned FLT_MANT_LO = 0;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_MUL  = 2'd1;
  localparam state_t ST_FIN  = 2'd2;

endpackage

// File: rtl/fmult_accum_fmult.sv
// Combinational G.726 FMULT: Q14 coefficient times 11-bit float,
// producing a 16-bit two's complement product term.
module fmult
  import fa_pkg::*;
(
  input  logic [COEF_W-1:0] coef,
  input  logic [FLT_W-1:0]  flt,
  output logic [ACC_W-1:0]  w
);

  logic        c_sgn;
  logic [12:0] c_mag;
  logic [3:0]  c_exp;
  logic [5:0]  c_mant;
  logic        f_sgn;
  logic [3:0]  f_exp;
  logic [5:0]  f_mant;
  logic [4:0]  w_exp;
  logic [7:0]  w_mant;
  logic [14:0] w_base;
  logic [14:0] w_mag;

  // Convert the coefficient to float, multiply mantissas, add exponents,
  // then denormalise back to a signed fixed-point magnitude.
  always_comb begin
    c_sgn  = coef[COEF_W-1];
    c_mag  = 13'((c_sgn ? -coef : coef) >> 2);
    c_exp  = '0;
    for (int unsigned i = 0; i < 13; i++) begin
      if (c_mag[i]) c_exp = 4'(i + 1);
    end
    c_mant = (c_mag == '0) ? 6'd32 : 6'({c_mag, 6'b0} >> c_exp);

    f_sgn  = flt[FLT_SIGN];
    f_exp  = flt[FLT_EXP_HI:FLT_EXP_LO];
    f_mant = flt[FLT_MANT_HI:FLT_MANT_LO];

    w_exp  = 5'(c_exp) + 5'(f_exp);
    w_mant = 8'((12'(c_mant) * 12'(f_mant) + 12'd48) >> 4);
    w_base = {w_mant, 7'b0};
    w_mag  = (w_exp > 5'd26) ? (w_base << (w_exp - 5'd26))
                             : (w_base >> (5'd26 - w_exp));
    w      = (c_sgn ^ f_sgn) ? -{1'b0, w_mag} : {1'b0, w_mag};
  end

endmodule

// File: rtl/fmult_accum.sv
// G.726 signal estimate: sequences six zero-predictor and two
// pole-predictor FMULT terms through one shared multiplier, one per clock,
// accumulating into SEZ (zero terms only) and SE (all terms).
module fmult_accum
  import fa_pkg::*;
#(
  parameter int unsigned NTERM_B = 6,
  parameter int unsigned NTERM_A = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                trig,
  input  logic [COEF_W-1:0]   b1,
  input  logic [COEF_W-1:0]   b2,
  input  logic [COEF_W-1:0]   b3,
  input  logic [COEF_W-1:0]   b4,
  input  logic [COEF_W-1:0]   b5,
  input  logic [COEF_W-1:0]   b6,
  input  logic [FLT_W-1:0]    dq1,
  input  logic [FLT_W-1:0]    dq2,
  input  logic [FLT_W-1:0]    dq3,
  input  logic [FLT_W-1:0]    dq4,
  input  logic [FLT_W-1:0]    dq5,
  input  logic [FLT_W-1:0]    dq6,
  input  logic [COEF_W-1:0]   a1,
  input  logic [COEF_W-1:0]   a2,
  input  logic [FLT_W-1:0]    sr1,
  input  logic [FLT_W-1:0]    sr2,
  output logic [EST_W-1:0]    sez,
  output logic [EST_W-1:0]    se,
  output logic                done,
  output logic                busy
);

  localparam int unsigned NTERM  = NTERM_B + NTERM_A;
  localparam logic [2:0]  LAST_B = 3'(NTERM_B - 1);
  localparam logic [2:0]  LAST   = 3'(NTERM - 1);

  state_t            state;
  logic [2:0]        idx;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_nxt;
  logic [ACC_W-1:0]  w;
  logic [COEF_W-1:0] coef_q [NTERM];
  logic [FLT_W-1:0]  flt_q  [NTERM];

  fmult u_fmult (
    .coef (coef_q[idx]),
    .flt  (flt_q[idx]),
    .w    (w)
  );

  assign acc_nxt = acc + w;
  assign done    = (state == ST_FIN);
  assign busy    = (state != ST_IDLE);

  // Snapshot all operands when a run is accepted so inputs may change mid-run.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && trig && !reset) begin
      coef_q[0] <= b1;  flt_q[0] <= dq1;
      coef_q[1] <= b2;  flt_q[1] <= dq2;
      coef_q[2] <= b3;  flt_q[2] <= dq3;
      coef_q[3] <= b4;  flt_q[3] <= dq4;
      coef_q[4] <= b5;  flt_q[4] <= dq5;
      coef_q[5] <= b6;  flt_q[5] <= dq6;
      coef_q[6] <= a1;  flt_q[6] <= sr1;
      coef_q[7] <= a2;  flt_q[7] <= sr2;
    end
  end

  // Sequencer and accumulator: one term per MUL cycle, modulo-2^16 sum.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      idx   <= '0;
      acc   <= '0;
      se    <= '0;
      sez   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (trig) begin
            idx   <= '0;
            acc   <= '0;
            state <= ST_MUL;
          end
        end
        ST_MUL: begin
          acc <= acc_nxt;
          idx <= idx + 3'd1;
          if (idx == LAST_B) sez <= acc_nxt[ACC_W-1:1];
          if (idx == LAST) begin
            se    <= acc_nxt[ACC_W-1:1];
            state <= ST_FIN;
          end
        end
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fmult_accum.md
Name: fmult_accum

Overview:
- Computes the G.726 signal estimate for one channel per trigger.
- Sequences 8 floating multiplies, one per clock:
  - six zero-predictor terms, Bn × DQn;
  - two pole-predictor terms, An × SRn.
- Accumulates them into SEZ and SE.
- Sits directly downstream of the control unit: started by the control unit's trigger pulse, and signals completion back on `done`, which feeds the control unit's done input.

Parameters:
- NTERM_B, 6, number of zero-predictor terms (fixed by G.726; not intended to change)
- NTERM_A, 2, number of pole-predictor terms (fixed by G.726)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous reset, active-high
- trig  in  1  start pulse from the control unit; sampled only in IDLE
- b1..b6  in  16 each  zero-predictor coefficients, two's complement, Q14
- dq1..dq6  in  11 each  delayed quantized difference, float format {sign, exp[3:0], mant[5:0]}
- a1, a2  in  16 each  pole-predictor coefficients, two's complement, Q14
- sr1, sr2  in  11 each  delayed reconstructed signal, same float format
- sez  out  15  partial (zero-only) estimate
- se  out  15  full signal estimate
- done  out  1  one-cycle completion strobe
- busy  out  1  high from trig acceptance until `done` deasserts

Behaviour:
- Reset (synchronous, active-high), including mid-operation:
  - state=IDLE, index=0, accumulator=0;
  - se=0, sez=0, done=0, busy=0;
  - any run in progress is abandoned with no `done`.
- States: IDLE, MUL, FIN.
- IDLE:
  - trig=1 at edge E0 → capture all 20 operands into holding registers, index=0, acc=0, state=MUL.
  - Inputs may change after E0.
- MUL:
  - At each edge E1..E8: acc ← acc + W(index) (16-bit, modulo 2^16, no saturation); then index++.
  - Index 0..5 selects (bN, dqN); index 6..7 selects (a1, sr1) and (a2, sr2).
  - At edge E6 (after the b6 term): sez ← acc_new[15:1].
  - At edge E8 (index 7): se ← acc_new[15:1]; state=FIN.
- FIN:
  - done=1 for exactly this one cycle (between E8 and E9).
  - Next edge → IDLE.
- Latency: `done` is asserted 8 clocks after the edge that sampled trig.
- se/sez hold their values until the next run overwrites them. sez changes mid-run, at E6.
- trig during MUL or FIN is ignored: no queueing, no restart.
- trig in the same cycle as FIN is also ignored; a new run may start from the first IDLE cycle.
- busy = (state != IDLE).
- FMULT arithmetic (combinational, per G.726):
  - cS = c[15]; cMAG = cS ? (-c)>>2 : c>>2, masked to 13 bits; cEXP = bit length of cMAG (0..13); cMANT = (cMAG==0) ? 32 : (cMAG<<6)>>cEXP.
  - WS = cS ^ fS; WEXP = cEXP + fEXP (5 bits); WMANT = (cMANT*fMANT + 48)>>4 (8 bits).
  - WMAG = (WEXP>26) ? (WMANT<<7)<<(WEXP-26) : (WMANT<<7)>>(26-WEXP), masked to 15 bits.
  - W = WS ? -WMAG : WMAG (16 bits).

Decomposition:
- Package fa_pkg holds:
  - width constants: COEF_W=16, FLT_W=11, ACC_W=16, EST_W=15;
  - state encoding for IDLE/MUL/FIN;
  - the float field slice positions.
- One sub-module, fmult:
  - purely combinational, one coefficient × one float → 16-bit W;
  - instantiated once, with its operands muxed by index.

Test Plan:
- All operands zero, trig pulse → done exactly 8 clocks later; se=0, sez=0; busy high for 9 cycles.
- a1=16'h2000, sr1={0,4'd5,6'd32}, all other terms zero → W=16; se=15'h0008, sez=0.
- a1=16'hE000, same sr1 → W=16'hFFF0; se=15'h7FF8.
- b1=16'h2000, dq1={0,4'd5,6'd32}, all other terms zero → sez=15'h0008, se=15'h0008.
- trig re-pulsed at E3 → ignored, single done at E8. Reset asserted at E4 → no done; se/sez=0; next trig completes normally.
- Randomized operands over 1000 runs → se/sez match the bit-exact G.726 C model, including 16-bit accumulator wrap.
